// File: rtl/morse_playback_ctrl.sv
// Morse playback sequencer: snapshots up to eight 5-element digit codes and
// plays them as a timed tone (dot 1u, dash 3u, element gap 1u, digit gap 3u).
module morse_playback_ctrl #(
  parameter int unsigned UNIT_CYCLES = 5_000_000,
  parameter int unsigned CNT_W       = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] count,
  input  logic [4:0] r0,
  input  logic [4:0] r1,
  input  logic [4:0] r2,
  input  logic [4:0] r3,
  input  logic [4:0] r4,
  input  logic [4:0] r5,
  input  logic [4:0] r6,
  input  logic [4:0] r7,
  output logic       tone,
  output logic       busy,
  output logic       done,
  output logic [2:0] digit_idx,
  output logic [2:0] elem_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_ON, S_GAP_ELEM, S_GAP_DIGIT, S_FIN
  } state_t;

  localparam logic [CNT_W-1:0] DOT_LD  = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DASH_LD = CNT_W'(3 * UNIT_CYCLES - 1);

  // Counter load for one element; the same values double as gap lengths.
  function automatic logic [CNT_W-1:0] elem_load(input logic dash);
    return dash ? DASH_LD : DOT_LD;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       digit_q, digit_d;
  logic [2:0]       elem_q, elem_d;
  logic [2:0]       last_q, last_d;
  logic [4:0]       codes_q [8];
  logic             load_codes;
  logic [4:0]       cur_code;
  logic [4:0]       nxt_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      digit_q <= '0;
      elem_q  <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      elem_q  <= elem_d;
      last_q  <= last_d;
    end
  end

  // Digit codes are pure data: captured on acceptance, never reset.
  always_ff @(posedge clk) begin
    if (load_codes) begin
      codes_q[0] <= r0;
      codes_q[1] <= r1;
      codes_q[2] <= r2;
      codes_q[3] <= r3;
      codes_q[4] <= r4;
      codes_q[5] <= r5;
      codes_q[6] <= r6;
      codes_q[7] <= r7;
    end
  end

  assign cur_code = codes_q[digit_q];
  assign nxt_code = codes_q[digit_q + 3'd1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    digit_d    = digit_q;
    elem_d     = elem_q;
    last_d     = last_q;
    load_codes = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && (count != 4'd0)) begin
          load_codes = 1'b1;
          last_d     = (count > 4'd8) ? 3'd7 : 3'(count - 4'd1);
          digit_d    = 3'd0;
          elem_d     = 3'd0;
          cnt_d      = elem_load(r0[4]);
          state_d    = S_ON;
        end
      end
      S_ON: begin
        if (cnt_q == '0) begin
          if (elem_q < 3'd4) begin
            cnt_d   = DOT_LD;
            state_d = S_GAP_ELEM;
          end else if (digit_q < last_q) begin
            cnt_d   = DASH_LD;
            state_d = S_GAP_DIGIT;
          end else begin
            state_d = S_FIN;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP_ELEM: begin
        if (cnt_q == '0) begin
          elem_d  = elem_q + 3'd1;
          cnt_d   = elem_load(cur_code[3'd3 - elem_q]);
          state_d = S_ON;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP_DIGIT: begin
        if (cnt_q == '0) begin
          digit_d = digit_q + 3'd1;
          elem_d  = 3'd0;
          cnt_d   = elem_load(nxt_code[4]);
          state_d = S_ON;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides every transition, including the FIN hand-off.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end
  end

  assign tone      = (state_q == S_ON);
  assign busy      = (state_q == S_ON) || (state_q == S_GAP_ELEM) ||
                     (state_q == S_GAP_DIGIT);
  assign done      = (state_q == S_FIN);
  assign digit_idx = digit_q;
  assign elem_idx  = elem_q;

endmodule

// File: tb/tb_morse_playback_ctrl.sv
// Bench for morse_playback_ctrl: expected waveform built from Morse timing
// rules into a queue and compared cycle by cycle against the DUT.
module tb_morse_playback_ctrl;
  localparam int U = 4;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [3:0] count;
  logic [4:0] r [8];
  logic       tone, busy, done;
  logic [2:0] digit_idx, elem_idx;

  morse_playback_ctrl #(.UNIT_CYCLES(U), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .count(count),
    .r0(r[0]), .r1(r[1]), .r2(r[2]), .r3(r[3]),
    .r4(r[4]), .r5(r[5]), .r6(r[6]), .r7(r[7]),
    .tone(tone), .busy(busy), .done(done),
    .digit_idx(digit_idx), .elem_idx(elem_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cnt;
    logic [39:0] codes;  // digit i at codes[i*5 +: 5]
    int          len;    // expected done offset from first tone cycle
  } vec_t;

  vec_t       vecs [3];
  logic [8:0] exp_q [$];  // {tone,busy,done,digit,elem}
  int         checks = 0;
  int         errors = 0;

  function automatic logic [8:0] obs();
    return {tone, busy, done, digit_idx, elem_idx};
  endfunction

  task automatic check(input string nm, input logic [8:0] act, input logic [8:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %b want %b", nm, $time, act, want);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask

  // Expected per-cycle outputs from the first tone cycle through the idle
  // cycle after done.
  task automatic build(input vec_t v);
    int n;
    int dur;
    logic [4:0] code;
    n = (v.cnt > 4'd8) ? 8 : int'(v.cnt);
    exp_q.delete();
    for (int d = 0; d < n; d++) begin
      code = v.codes[d*5 +: 5];
      for (int e = 0; e < 5; e++) begin
        dur = code[4-e] ? 3*U : U;
        repeat (dur) exp_q.push_back({1'b1, 1'b1, 1'b0, 3'(d), 3'(e)});
        if (e < 4)
          repeat (U) exp_q.push_back({1'b0, 1'b1, 1'b0, 3'(d), 3'(e)});
        else if (d < n-1)
          repeat (3*U) exp_q.push_back({1'b0, 1'b1, 1'b0, 3'(d), 3'(e)});
      end
    end
    exp_q.push_back({1'b0, 1'b0, 1'b1, 3'(n-1), 3'd4});
    exp_q.push_back({1'b0, 1'b0, 1'b0, 3'(n-1), 3'd4});
  endtask

  // Called at a negedge. Returns early at cycle stop_at (>=0) mid-playback.
  task automatic run(input vec_t v, input int stop_at, input bit disturb);
    int t;
    int done_t;
    logic [8:0] e;
    count = v.cnt;
    for (int i = 0; i < 8; i++) r[i] = v.codes[i*5 +: 5];
    start = 1'b1;
    build(v);
    @(negedge clk);
    start = 1'b0;
    t = 0;
    done_t = -1;
    while (exp_q.size() > 0) begin
      if (t == stop_at) begin
        exp_q.delete();
        return;
      end
      e = exp_q.pop_front();
      check("wave", obs(), e);
      if (done) done_t = t;
      if (disturb && t == 10) begin
        r[0] = ~r[0];
        count = 4'd3;
        start = 1'b1;
      end
      if (disturb && t == 11) start = 1'b0;
      t++;
      @(negedge clk);
    end
    check_int("done_offset", done_t, v.len);
  endtask

  initial begin
    vecs[0] = '{cnt: 4'd1,  codes: {35'd0, 5'b01111}, len: 68};
    vecs[1] = '{cnt: 4'd2,  codes: {30'd0, 5'b11111, 5'b00000}, len: 124};
    vecs[2] = '{cnt: 4'd12, codes: {8{5'b10101}}, len: 564};

    rst = 1'b1; start = 1'b0; abort = 1'b0; count = 4'd0;
    for (int i = 0; i < 8; i++) r[i] = 5'd0;
    repeat (3) @(negedge clk);
    check("reset", obs(), 9'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset", obs(), 9'd0);

    for (int i = 0; i < 3; i++) run(vecs[i], -1, 1'b0);

    // count=0 start is ignored
    count = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      check("zero_count", {6'd0, tone, busy, done}, 9'd0);
      @(negedge clk);
    end

    // abort in cycle 6 of the first dash
    run(vecs[0], 13, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_now", {6'd0, tone, busy, done}, 9'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("abort_quiet", {6'd0, tone, busy, done}, 9'd0);
    end
    run(vecs[0], -1, 1'b0);

    // input changes and a second start during playback have no effect
    run(vecs[0], -1, 1'b1);

    // reset mid-playback
    run(vecs[1], 20, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid", obs(), 9'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_quiet", obs(), 9'd0);
    end
    run(vecs[0], -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
